alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//   Execute stage that consumes the 4-bit ALU operation code produced by the ALU control decoder.
//   Operands and opcode arrive over a valid/ready request channel.
//   The result leaves over a valid/ready response channel.
//   Logic/arith ops take one cycle; shifts run iteratively, one bit per cycle.
//   Sits between decode/regfile read and writeback in the multi-cycle datapath.
// PARAMETERS
//   WIDTH    32  operand/result width in bits
//   SHAMT_W  5   shift-amount width; must equal $clog2(WIDTH)
// PORTS
//   clk        in   1        single clock, rising edge
//   reset      in   1        asynchronous, active-high
//   in_valid   in   1        request valid
//   in_ready   out  1        unit can accept request
//   operation  in   4        ALU op code (encoding below)
//   a          in   WIDTH    operand A (rs)
//   b          in   WIDTH    operand B (rt / immediate)
//   shamt      in   SHAMT_W  shift amount for SLL/SRL
//   out_valid  out  1        result valid
//   out_ready  in   1        consumer takes result
//   result     out  WIDTH    result
//   zero       out  1        result == 0
//   overflow   out  1        signed overflow (ADD/SUB only, else 0)
//   illegal    out  1        operation code not defined
// BEHAVIOUR
//   Encoding:
//     0000 ADD a+b; 0001 SUB a-b; 0010 AND; 0011 OR; 0100 XOR.
//     0101 SLL b<<shamt; 0110 SRL b>>shamt (zero fill).
//     0111 SLT: result = {0..,($signed(a)<$signed(b))}.
//     1xxx: illegal -> result 0, illegal=1, zero=1, latency as ALU op.
//   Reset (async):
//     State -> IDLE; in_ready=1; out_valid=0.
//     result=0, zero=0, overflow=0, illegal=0; shift counter=0.
//   FSM states: IDLE, SHIFT, DONE.
//   IDLE:
//     in_ready=1, out_valid=0.
//     Accept on in_valid&&in_ready; capture operation, a, b, shamt.
//     Non-shift op -> result/flags registered -> DONE.
//     Shift op with shamt==0 -> result=b -> DONE.
//     Shift op with shamt!=0 -> acc=b, cnt=shamt -> SHIFT.
//   SHIFT:
//     in_ready=0.
//     Each cycle acc shifts 1 bit in captured direction; cnt decrements.
//     When cnt==1 at a shift edge -> DONE.
//   DONE:
//     out_valid=1; result/flags held stable while out_ready=0.
//     On out_valid&&out_ready -> IDLE.
//     No new request accepted in the same cycle (in_ready=0 in DONE).
//   Latency (accept edge to out_valid): 1 cycle for non-shift ops; 1+shamt cycles for shifts.
//   Arithmetic:
//     ADD/SUB wrap modulo 2^WIDTH.
//     overflow = operand signs equal (ADD) / differ (SUB) and result sign differs from a.
//     zero is computed on the final result for all ops, including shifts.
//   Inputs are ignored outside the accept cycle; input changes mid-op have no effect.
//   Reset mid-operation (SHIFT or DONE) aborts immediately; pending result is discarded.
//   Throughput: at most one request per 2 cycles (IDLE->DONE->IDLE).
// TESTING
//   1. ADD: a=0x7FFFFFFF, b=1, out_ready=1
//      -> out_valid 1 cycle after accept; result=0x80000000; overflow=1; zero=0.
//   2. SUB: a=5, b=5 -> result=0, zero=1, overflow=0.
//      SLT: a=0xFFFFFFFF, b=1 -> result=1.
//   3. SLL: b=0x1, shamt=31 -> out_valid exactly 32 cycles after accept; result=0x80000000.
//      SRL: b=0x80000000, shamt=0 -> result=0x80000000 after 1 cycle.
//   4. Backpressure: hold out_ready=0 for 5 cycles after XOR a=0xF0F0, b=0xFF00
//      -> result=0xF0F0^0xFF00=0x0FF0 held stable; in_ready=0 throughout.
//      Pulse out_ready -> IDLE next cycle.
//   5. operation=1010 -> result=0, illegal=1, zero=1 after 1 cycle.
//   6. Assert reset during SHIFT with shamt=20, cnt mid-way
//      -> out_valid=0, in_ready=1 immediately (async); no stale result emitted afterwards.

Source files
------------

// File: rtl/alu_exec_unit_if.sv
// Request/response channel between the issue logic and the ALU execute unit.
// The master drives operands and out_ready; the slave returns the result and its flags.
interface alu_exec_unit_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [3:0]         operation;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [SHAMT_W-1:0] shamt;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   result;
  logic               zero;
  logic               overflow;
  logic               illegal;

  modport master (
    output in_valid, operation, a, b, shamt, out_ready,
    input  in_ready, out_valid, result, zero, overflow, illegal
  );

  modport slave (
    input  in_valid, operation, a, b, shamt, out_ready,
    output in_ready, out_valid, result, zero, overflow, illegal
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute stage: single-cycle logic/arith ops, iterative one-bit-per-cycle shifts,
// with a valid/ready request channel in and a valid/ready response channel out.
module alu_exec_unit #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic           clk,
  input  logic           reset,
  alu_exec_unit_if.slave bus
);
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_acc;
  logic [SHAMT_W-1:0] r_cnt;
  logic               r_shl;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero;
  logic               r_overflow;
  logic               r_illegal;

  logic               w_accept;
  logic               w_shift_done;
  logic               w_is_shift;
  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH-1:0]   w_alu_res;
  logic               w_alu_ovf;
  logic               w_alu_ill;
  logic [WIDTH-1:0]   w_shift_nxt;

  // Single-cycle result for the live request; shifts pass b through for the shamt==0 case
  always_comb begin
    w_sum      = bus.a + bus.b;
    w_diff     = bus.a - bus.b;
    w_alu_res  = '0;
    w_alu_ovf  = 1'b0;
    w_alu_ill  = 1'b0;
    w_is_shift = 1'b0;
    case (bus.operation)
      OP_ADD: begin
        w_alu_res = w_sum;
        w_alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        w_alu_res = w_diff;
        w_alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (w_diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND: w_alu_res = bus.a & bus.b;
      OP_OR:  w_alu_res = bus.a | bus.b;
      OP_XOR: w_alu_res = bus.a ^ bus.b;
      OP_SLL, OP_SRL: begin
        w_alu_res  = bus.b;
        w_is_shift = 1'b1;
      end
      OP_SLT: w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      default: w_alu_ill = 1'b1;
    endcase
  end

  assign w_shift_nxt = r_shl ? (r_acc << 1) : (r_acc >> 1);

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_shift_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.in_valid && r_in_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = (w_is_shift && (bus.shamt != '0)) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (r_cnt == SHAMT_W'(1)) begin
          w_shift_done = 1'b1;
          w_state_nxt  = DONE;
        end
      end
      DONE: begin
        if (r_out_valid && bus.out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Handshake outputs are registered copies of the next-state decode
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_shl      <= 1'b0;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_overflow <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (w_accept) begin
      if (w_state_nxt == SHIFT) begin
        r_acc <= bus.b;
        r_cnt <= bus.shamt;
        r_shl <= (bus.operation == OP_SLL);
      end else begin
        r_result   <= w_alu_res;
        r_zero     <= (w_alu_res == '0);
        r_overflow <= w_alu_ovf;
        r_illegal  <= w_alu_ill;
      end
    end else if (r_state == SHIFT) begin
      r_acc <= w_shift_nxt;
      r_cnt <= r_cnt - SHAMT_W'(1);
      if (w_shift_done) begin
        r_result   <= w_shift_nxt;
        r_zero     <= (w_shift_nxt == '0);
        r_overflow <= 1'b0;
        r_illegal  <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.zero      = r_zero;
  assign bus.overflow  = r_overflow;
  assign bus.illegal   = r_illegal;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized self-checking bench for alu_exec_unit against an arithmetic reference model.
module tb_alu_exec_unit;
  localparam int unsigned WIDTH   = 32;
  localparam int unsigned SHAMT_W = 5;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  alu_exec_unit_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) bus ();

  alu_exec_unit #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: signed ranges via 64-bit integers, shifts as whole-word operators
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, output logic [31:0] r, output logic z,
                       output logic ov, output logic il, output int lat);
    int    ia;
    int    ib;
    longint s;
    ia  = a;
    ib  = b;
    r   = 32'd0;
    ov  = 1'b0;
    il  = 1'b0;
    lat = 1;
    s   = 64'sd0;
    if (op[3]) il = 1'b1;
    else begin
      case (op[2:0])
        3'd0: begin r = a + b; s = longint'(ia) + longint'(ib); end
        3'd1: begin r = a - b; s = longint'(ia) - longint'(ib); end
        3'd2: r = a & b;
        3'd3: r = a | b;
        3'd4: r = a ^ b;
        3'd5: begin r = b << sh; lat = 1 + int'(sh); end
        3'd6: begin r = b >> sh; lat = 1 + int'(sh); end
        default: r = (ia < ib) ? 32'd1 : 32'd0;
      endcase
      ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end
    z = (r == 32'd0);
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input int hold);
    logic [31:0] er;
    logic        ez;
    logic        eo;
    logic        ei;
    int          elat;
    int          lat;
    model(op, a, b, sh, er, ez, eo, ei, elat);
    @(negedge clk);
    check("in_ready_idle", 64'(bus.in_ready), 64'd1);
    bus.in_valid  = 1'b1;
    bus.operation = op;
    bus.a         = a;
    bus.b         = b;
    bus.shamt     = sh;
    bus.out_ready = (hold == 0);
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.operation = 4'($urandom);
    bus.a         = $urandom;
    bus.b         = $urandom;
    bus.shamt     = 5'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 64) begin
      check("in_ready_busy", 64'(bus.in_ready), 64'd0);
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(elat));
    check("result", 64'(bus.result), 64'(er));
    check("zero", 64'(bus.zero), 64'(ez));
    check("overflow", 64'(bus.overflow), 64'(eo));
    check("illegal", 64'(bus.illegal), 64'(ei));
    check("in_ready_done", 64'(bus.in_ready), 64'd0);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        check("held_valid", 64'(bus.out_valid), 64'd1);
        check("held_result", 64'(bus.result), 64'(er));
        check("held_in_ready", 64'(bus.in_ready), 64'd0);
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("valid_after_take", 64'(bus.out_valid), 64'd0);
    check("ready_after_take", 64'(bus.in_ready), 64'd1);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'h0000_0000;
      1: v = 32'h0000_0001;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'h7FFF_FFFF;
      4: v = 32'h8000_0000;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    logic [3:0] op;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.operation = 4'd0;
    bus.a         = 32'd0;
    bus.b         = 32'd0;
    bus.shamt     = 5'd0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_zero", 64'(bus.zero), 64'd0);
    check("rst_overflow", 64'(bus.overflow), 64'd0);
    check("rst_illegal", 64'(bus.illegal), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op(4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 0);
    run_op(4'b0001, 32'd5, 32'd5, 5'd0, 0);
    run_op(4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd0, 1);
    run_op(4'b0101, 32'd0, 32'h0000_0001, 5'd31, 0);
    run_op(4'b0110, 32'd0, 32'h8000_0000, 5'd0, 0);
    run_op(4'b0110, 32'd0, 32'h8000_0000, 5'd31, 2);
    run_op(4'b0100, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, 5);
    run_op(4'b1010, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3, 0);
    run_op(4'b0001, 32'h8000_0000, 32'h0000_0001, 5'd0, 0);

    // Abort a 20-step shift part-way through with an asynchronous reset
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.operation = 4'b0101;
    bus.b         = 32'h0000_0001;
    bus.shamt     = 5'd20;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort_out_valid", 64'(bus.out_valid), 64'd0);
    check("abort_in_ready", 64'(bus.in_ready), 64'd1);
    check("abort_result", 64'(bus.result), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (25) begin
      @(posedge clk);
      #1;
      check("no_stale_valid", 64'(bus.out_valid), 64'd0);
    end
    bus.out_ready = 1'b0;

    for (int n = 0; n < 60; n++) begin
      op = ($urandom_range(0, 7) == 0) ? 4'(8 + $urandom_range(0, 7)) : 4'($urandom_range(0, 7));
      run_op(op, pick_operand(), pick_operand(), 5'($urandom), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
